// File: rtl/pc_audio_mixer.sv
// Mixes the PC speaker bit, Tandy 8-bit level and OPL2 sample into one signed
// 16-bit PCM stream, one sample per SAMPLE_DIV clocks, with a 3-stage pipeline.
module pc_audio_mixer #(
    parameter logic        [15:0] SAMPLE_DIV = 16'd298,
    parameter logic signed [15:0] SPK_LEVEL  = 16'sd8192
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        speaker_in,
    input  logic [7:0]  tandy_in,
    input  logic [15:0] opl2_in,
    input  logic [1:0]  spk_vol,
    input  logic [1:0]  tandy_vol,
    input  logic [1:0]  opl2_vol,
    output logic [15:0] sample_out,
    output logic        sample_valid
);

    function automatic logic signed [15:0] vol_scale(input logic signed [15:0] v,
                                                     input logic [1:0] vol);
        case (vol)
            2'd0:    vol_scale = 16'sd0;
            2'd1:    vol_scale = v >>> 2;
            2'd2:    vol_scale = v >>> 1;
            default: vol_scale = v;
        endcase
    endfunction

    logic               r_s1, r_s2;
    logic signed [15:0] r_y;
    logic        [15:0] r_cnt;
    logic signed [15:0] r_spk_t, r_tan_t, r_opl_t;
    logic signed [17:0] r_sum;
    logic        [1:0]  r_vld_pipe;

    logic signed [15:0] w_x;
    logic signed [16:0] w_diff;
    logic signed [16:0] w_step;
    logic signed [8:0]  w_tan_c;
    logic signed [15:0] w_tan;
    logic               w_tick;

    // One-pole low-pass: 17-bit difference keeps the full +/-2*SPK_LEVEL swing.
    assign w_x     = r_s2 ? SPK_LEVEL : -SPK_LEVEL;
    assign w_diff  = {w_x[15], w_x} - {r_y[15], r_y};
    assign w_step  = w_diff >>> 4;

    assign w_tan_c = $signed({1'b0, tandy_in}) - 9'sd128;
    assign w_tan   = {w_tan_c[8], w_tan_c, 6'b0};

    assign w_tick  = (r_cnt == SAMPLE_DIV - 16'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_y  <= '0;
        end else begin
            r_s1 <= speaker_in;
            r_s2 <= r_s1;
            r_y  <= r_y + w_step[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_spk_t      <= '0;
            r_tan_t      <= '0;
            r_opl_t      <= '0;
            r_sum        <= '0;
            r_vld_pipe   <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[0], w_tick};
            sample_valid <= r_vld_pipe[1];
            if (w_tick) begin
                r_spk_t <= vol_scale(r_y, spk_vol);
                r_tan_t <= vol_scale(w_tan, tandy_vol);
                r_opl_t <= vol_scale($signed(opl2_in), opl2_vol);
            end
            if (r_vld_pipe[0])
                r_sum <= {{2{r_spk_t[15]}}, r_spk_t} + {{2{r_tan_t[15]}}, r_tan_t}
                       + {{2{r_opl_t[15]}}, r_opl_t};
            if (r_vld_pipe[1]) begin
                if (r_sum > 18'sd32767)
                    sample_out <= 16'h7FFF;
                else if (r_sum < -18'sd32768)
                    sample_out <= 16'h8000;
                else
                    sample_out <= r_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_pc_audio_mixer.sv
// Directed bench for pc_audio_mixer: default divider instance plus a
// SAMPLE_DIV=4 instance for the minimum-divider cadence.
module tb_pc_audio_mixer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        speaker_in;
    logic [7:0]  tandy_in;
    logic [15:0] opl2_in;
    logic [1:0]  spk_vol, tandy_vol, opl2_vol;
    logic [15:0] sample_out;
    logic        sample_valid;

    logic        reset4_n;
    logic [15:0] opl4_in;
    logic [15:0] sample4_out;
    logic        sample4_valid;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_audio_mixer dut (
        .clock(clock), .reset_n(reset_n), .speaker_in(speaker_in),
        .tandy_in(tandy_in), .opl2_in(opl2_in), .spk_vol(spk_vol),
        .tandy_vol(tandy_vol), .opl2_vol(opl2_vol),
        .sample_out(sample_out), .sample_valid(sample_valid)
    );

    pc_audio_mixer #(.SAMPLE_DIV(16'd4)) dut4 (
        .clock(clock), .reset_n(reset4_n), .speaker_in(1'b0),
        .tandy_in(8'h80), .opl2_in(opl4_in), .spk_vol(2'd0),
        .tandy_vol(2'd0), .opl2_vol(2'd3),
        .sample_out(sample4_out), .sample_valid(sample4_valid)
    );

    // Advance negedge by negedge until the next pulse; ok=0 if none in budget.
    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clock);
            if (sample_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        speaker_in = 1'b0; tandy_in = 8'h80; opl2_in = 16'h0;
        spk_vol = 2'd0; tandy_vol = 2'd0; opl2_vol = 2'd0;
        repeat (3) @(negedge clock);
        checks++;
        if (sample_out !== 16'h0) begin
            errors++; $display("FAIL reset_out got %h want 0000", sample_out);
        end
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", sample_valid);
        end
        reset_n = 1'b1;
        for (int c = 0; c <= 900; c++) begin
            logic exp_v;
            exp_v = (c == 300 || c == 598 || c == 896);
            checks++;
            if (sample_valid !== exp_v) begin
                errors++; $display("FAIL idle_valid cycle %0d got %b want %b", c, sample_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (sample_out !== 16'h0) begin
                    errors++; $display("FAIL idle_out cycle %0d got %h want 0000", c, sample_out);
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_tandy;
        logic [7:0]  tv  [4] = '{8'hFF, 8'h80, 8'h00, 8'hFF};
        logic [1:0]  vv  [4] = '{2'd3, 2'd3, 2'd3, 2'd2};
        logic [15:0] ev  [4] = '{16'd8128, 16'd0, 16'hE000, 16'd4064};
        bit ok1, ok2;
        spk_vol = 2'd0; opl2_vol = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tandy_in = tv[i]; tandy_vol = vv[i];
            wait_pulse(ok1); wait_pulse(ok2);
            checks++;
            if (!ok1 || !ok2 || sample_out !== ev[i]) begin
                errors++; $display("FAIL tandy_%0d got %h want %h", i, sample_out, ev[i]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [15:0] ov [3] = '{16'h7FFF, 16'h8000, 16'd1000};
        logic [7:0]  tv [3] = '{8'hFF, 8'h00, 8'h80};
        logic [15:0] ev [3] = '{16'h7FFF, 16'h8000, 16'd1000};
        bit ok1, ok2;
        spk_vol = 2'd0; opl2_vol = 2'd3; tandy_vol = 2'd3;
        for (int i = 0; i < 3; i++) begin
            opl2_in = ov[i]; tandy_in = tv[i];
            wait_pulse(ok1); wait_pulse(ok2);
            checks++;
            if (!ok1 || !ok2 || sample_out !== ev[i]) begin
                errors++; $display("FAIL sat_%0d got %h want %h", i, sample_out, ev[i]);
            end
        end
    endtask

    task automatic test_speaker;
        bit ok1, ok2;
        opl2_in = 16'h0; tandy_in = 8'h80;
        opl2_vol = 2'd0; tandy_vol = 2'd0; spk_vol = 2'd3;
        speaker_in = 1'b1;
        repeat (400) @(negedge clock);
        wait_pulse(ok1);
        checks++;
        if (!ok1 || $signed(sample_out) < 16'sd8177 || $signed(sample_out) > 16'sd8192) begin
            errors++; $display("FAIL spk_high got %0d want 8177..8192", $signed(sample_out));
        end
        speaker_in = 1'b0;
        repeat (400) @(negedge clock);
        wait_pulse(ok1);
        checks++;
        if (!ok1 || sample_out !== 16'hE000) begin
            errors++; $display("FAIL spk_low got %0d want -8192", $signed(sample_out));
        end
        spk_vol = 2'd1;
        wait_pulse(ok1); wait_pulse(ok2);
        checks++;
        if (!ok1 || !ok2 || sample_out !== 16'hF800) begin
            errors++; $display("FAIL spk_vol1 got %0d want -2048", $signed(sample_out));
        end
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2;
        spk_vol = 2'd0; tandy_vol = 2'd0; opl2_vol = 2'd3; opl2_in = 16'd1000;
        wait_pulse(ok1); wait_pulse(ok2);
        checks++;
        if (!ok1 || !ok2 || sample_out !== 16'd1000) begin
            errors++; $display("FAIL premid_out got %h want %h", sample_out, 16'd1000);
        end
        // Now in the pulse cycle P; the next tick is at P+295.
        repeat (296) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if (sample_out !== 16'h0) begin
            errors++; $display("FAIL mid_out got %h want 0000", sample_out);
        end
        for (int c = 0; c <= 301; c++) begin
            logic exp_v;
            exp_v = (c == 300);
            checks++;
            if (sample_valid !== exp_v) begin
                errors++; $display("FAIL mid_valid cycle %0d got %b want %b", c, sample_valid, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_min_div;
        reset4_n = 1'b0;
        opl4_in = 16'h0;
        repeat (2) @(negedge clock);
        reset4_n = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            logic        exp_v;
            logic [15:0] exp_o;
            exp_v = (c >= 6) && ((c - 6) % 4 == 0);
            checks++;
            if (sample4_valid !== exp_v) begin
                errors++; $display("FAIL div4_valid cycle %0d got %b want %b", c, sample4_valid, exp_v);
            end
            if (exp_v) begin
                exp_o = 16'(100 * ((c - 3) / 4 + 1));
                checks++;
                if (sample4_out !== exp_o) begin
                    errors++; $display("FAIL div4_out cycle %0d got %0d want %0d", c, sample4_out, exp_o);
                end
            end else if (c < 6) begin
                checks++;
                if (sample4_out !== 16'h0) begin
                    errors++; $display("FAIL div4_init cycle %0d got %h want 0000", c, sample4_out);
                end
            end
            opl4_in = 16'(100 * (c / 4 + 1));
            @(negedge clock);
        end
    endtask

    initial begin
        reset4_n = 1'b0;
        opl4_in  = 16'h0;
        test_reset();
        test_tandy();
        test_saturation();
        test_speaker();
        test_reset_mid();
        test_min_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
